inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  - Writer side of the instruction-RAM load port: turns a byte stream (from the UART rx
//    or DMA byte path) into 32-bit words and drives is_write/im_addr/im_inst.
//  - Holds the pipelined core in reset (core_hold) until a complete program is loaded,
//    then releases it. Stream format: 2-byte LE word count N, then 4*N payload bytes, LE per word.
// PARAMETERS
//  - W          32      data/address width; matches the instruction RAM
//  - BASE_ADDR  0       byte address of the first word written
//  - MAX_WORDS  2048    largest accepted N; larger N is an error
// PORTS
//  - clk           in   1    clock, rising edge
//  - rst_n         in   1    asynchronous active-low reset
//  - start         in   1    one-cycle pulse that begins a load session
//  - byte_in       in   8    stream byte
//  - byte_valid    in   1    byte_in valid
//  - byte_ready    out  1    loader accepts byte; transfer when valid & ready
//  - is_write      out  1    RAM write strobe, one cycle per word
//  - im_addr       out  W    RAM byte address, BASE_ADDR + 4*k
//  - im_inst       out  W    assembled word
//  - core_hold     out  1    1 = keep core in reset
//  - done          out  1    level, load completed successfully
//  - error         out  1    level, load aborted
//  - words_loaded  out  16   words written this session
// BEHAVIOUR
//  - Reset: state IDLE; byte_ready=0, is_write=0, im_addr=BASE_ADDR, im_inst=0,
//    core_hold=1, done=0, error=0, words_loaded=0.
//  - States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM (macro only), DONE, ERR.
//  - IDLE/DONE/ERR --start--> LEN0; clears done, error, words_loaded, byte counter,
//    checksum; core_hold=1. start in any other state is ignored.
//  - byte_ready=1 only in LEN0, LEN1, DATA, CSUM; 0 elsewhere (WRITE is a 1-cycle bubble).
//  - LEN0: accepted byte -> N[7:0]. LEN1: accepted byte -> N[15:8]; then
//    N==0 -> DONE (no writes); N>MAX_WORDS -> ERR (no writes); else -> DATA.
//  - DATA: byte j of word (j=0..3) goes to word[8j+7:8j]; on acceptance of j=3 go to WRITE.
//  - WRITE (exactly 1 cycle): is_write=1, im_inst=word, im_addr=BASE_ADDR+4*k (k = words_loaded);
//    words_loaded increments at cycle end. Next: k+1<N -> DATA, else -> DONE (or CSUM with macro).
//  - im_addr/im_inst hold their last value when is_write=0; address arithmetic is W bits, wraps mod 2^W.
//  - DONE: done=1, core_hold=0 (registered, first cycle in DONE). ERR: error=1, core_hold=1.
//  - byte_valid low stalls any state indefinitely; no timeout. Bytes with byte_ready=0 are not consumed.
//  - Reset mid-load: immediate return to reset values; words already written are not erased.
//  - Latency: is_write asserts the cycle after the 4th byte of a word is accepted;
//    done asserts the cycle after the last WRITE (no macro).
// CONFIGURATION
//  - INST_LOADER_CHECKSUM_EN defined: after the last WRITE, state CSUM accepts one byte;
//    equal to XOR of all 4*N payload bytes -> DONE, else -> ERR (words remain written).
//    N==0 also goes through CSUM (expected value 0x00).
//  - Not defined: no CSUM state; stream ends after payload; last WRITE -> DONE.
// TESTING
//  - Reset then idle: core_hold=1, byte_ready=0, is_write never asserts, words_loaded=0.
//  - start; bytes 02 00 13 00 00 00 B3 00 A0 00 -> two writes: (0x0,0x00000013), (0x4,0x00A000B3); done=1, core_hold=0.
//  - Same stream with byte_valid toggled every other cycle -> identical writes, no lost/duplicated bytes.
//  - start; bytes 01 08 (N=2049) -> error=1, core_hold=1, no is_write; start again with 00 00 -> done=1.
//  - rst_n low after 5 payload bytes -> outputs at reset values; a fresh start then loads from im_addr=BASE_ADDR.
//  - INST_LOADER_CHECKSUM_EN: N=1, payload 11 22 33 44, csum 44 -> done; csum 45 -> error, one write seen.

Source files
------------

// File: rtl/inst_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------------+
// | inst_loader : byte stream (LE count N, then 4*N LE payload bytes) -> instruction |
// | RAM writes; holds the core in reset until a program has loaded.                 |
// | Optional trailing XOR checksum byte: define INST_LOADER_CHECKSUM_EN.            |
// | Rev 1.0                                                                         |
// +---------------------------------------------------------------------------------+
module inst_loader #(
   parameter int unsigned  W         = 32,
   parameter logic [W-1:0] BASE_ADDR = '0,
   parameter int unsigned  MAX_WORDS = 2048
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   byte_in,
   input  logic         byte_valid,
   output logic         byte_ready,
   output logic         is_write,
   output logic [W-1:0] im_addr,
   output logic [W-1:0] im_inst,
   output logic         core_hold,
   output logic         done,
   output logic         error,
   output logic [15:0]  words_loaded
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_WRITE = 3'd4,
      ST_CSUM  = 3'd5,
      ST_DONE  = 3'd6,
      ST_ERR   = 3'd7
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    n_q, n_d;
   logic [31:0]    word_q, word_d;
   logic [1:0]     byte_cnt_q, byte_cnt_d;
   logic [15:0]    words_loaded_q, words_loaded_d;
   logic           byte_ready_q, byte_ready_d;
   logic           is_write_q, is_write_d;
   logic [W-1:0]   im_addr_q, im_addr_d;
   logic [W-1:0]   im_inst_q, im_inst_d;
   logic           core_hold_q, core_hold_d;
   logic           done_q, done_d;
   logic           error_q, error_d;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]     csum_q, csum_d;
`endif

   logic           xfer;
   logic [15:0]    len_full;
   logic [31:0]    word_full;
   logic [W-1:0]   wr_addr;
   logic [16:0]    next_k;

   assign xfer      = byte_valid & byte_ready_q;
   assign len_full  = {byte_in, n_q[7:0]};
   // Bytes shift in from the top so the first byte ends up in [7:0] after four transfers.
   assign word_full = {byte_in, word_q[31:8]};
   assign wr_addr   = BASE_ADDR + W'({words_loaded_q, 2'b00});
   assign next_k    = {1'b0, words_loaded_q} + 17'd1;

   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      word_d         = word_q;
      byte_cnt_d     = byte_cnt_q;
      words_loaded_d = words_loaded_q;
      im_addr_d      = im_addr_q;
      im_inst_d      = im_inst_q;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d         = csum_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d        = ST_LEN0;
               words_loaded_d = 16'd0;
               byte_cnt_d     = 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
               csum_d         = 8'h00;
`endif
            end
         end
         ST_LEN0: begin
            if (xfer) begin
               n_d[7:0] = byte_in;
               state_d  = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (xfer) begin
               n_d[15:8] = byte_in;
               if (len_full == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else if ({16'd0, len_full} > MAX_WORDS) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               word_d     = word_full;
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ byte_in;
`endif
               if (byte_cnt_q == 2'd3) begin
                  state_d   = ST_WRITE;
                  im_inst_d = W'(word_full);
                  im_addr_d = wr_addr;
               end
            end
         end
         ST_WRITE: begin
            words_loaded_d = words_loaded_q + 16'd1;
            if (next_k < {1'b0, n_q}) begin
               state_d = ST_DATA;
            end else begin
`ifdef INST_LOADER_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef INST_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (xfer) begin
               state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with the state they describe.
      byte_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                     (state_d == ST_DATA) || (state_d == ST_CSUM);
      is_write_d   = (state_d == ST_WRITE);
      core_hold_d  = (state_d != ST_DONE);
      done_d       = (state_d == ST_DONE);
      error_d      = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         n_q            <= 16'd0;
         word_q         <= 32'd0;
         byte_cnt_q     <= 2'd0;
         words_loaded_q <= 16'd0;
         byte_ready_q   <= 1'b0;
         is_write_q     <= 1'b0;
         im_addr_q      <= BASE_ADDR;
         im_inst_q      <= '0;
         core_hold_q    <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q         <= 8'h00;
`endif
      end else begin
         state_q        <= state_d;
         n_q            <= n_d;
         word_q         <= word_d;
         byte_cnt_q     <= byte_cnt_d;
         words_loaded_q <= words_loaded_d;
         byte_ready_q   <= byte_ready_d;
         is_write_q     <= is_write_d;
         im_addr_q      <= im_addr_d;
         im_inst_q      <= im_inst_d;
         core_hold_q    <= core_hold_d;
         done_q         <= done_d;
         error_q        <= error_d;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q         <= csum_d;
`endif
      end
   end

   assign byte_ready   = byte_ready_q;
   assign is_write     = is_write_q;
   assign im_addr      = im_addr_q;
   assign im_inst      = im_inst_q;
   assign core_hold    = core_hold_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// tb_inst_loader: load sessions (directed + random) checked against a stream-parsing reference model.
module tb_inst_loader;

   localparam int          W    = 32;
   localparam logic [31:0] BASE = 32'h0;
   localparam int          MAXW = 2048;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid = 1'b0;
   logic          byte_ready;
   logic          is_write;
   logic [W-1:0]  im_addr;
   logic [W-1:0]  im_inst;
   logic          core_hold;
   logic          done;
   logic          error;
   logic [15:0]   words_loaded;

   int            total = 0;
   int            bad = 0;
   logic [63:0]   wr_q[$];
   logic [31:0]   fixed_q[$];

   always #5 clk = ~clk;

   inst_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .is_write     (is_write),
      .im_addr      (im_addr),
      .im_inst      (im_inst),
      .core_hold    (core_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   // is_write is high for one full clock period, so one negedge sample per write.
   always @(negedge clk) if (is_write) wr_q.push_back({im_addr, im_inst});

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+#1; returns at posedge+#1 right after the byte was taken.
   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      ok = 1'b0;
      byte_valid = 1'b0;
      repeat (gap) begin
         byte_in = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_in = b;
      byte_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (byte_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string pfx);
      chk({pfx, "_byte_ready"}, byte_ready, 0);
      chk({pfx, "_is_write"}, is_write, 0);
      chk({pfx, "_im_addr"}, im_addr, BASE);
      chk({pfx, "_im_inst"}, im_inst, 0);
      chk({pfx, "_core_hold"}, core_hold, 1);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_error"}, error, 0);
      chk({pfx, "_words_loaded"}, words_loaded, 0);
   endtask

   // Builds a stream for count n (payload from fixed_q, else random), predicts the outcome, runs it.
   task automatic session(input int n, input int gap_mode, input bit bad_csum);
      logic [7:0]  s[$];
      logic [63:0] exp_w[$];
      logic [7:0]  x;
      logic [15:0] n16;
      bit          exp_err, exp_done, ok;
      int          nw, gap;
      n16 = 16'(n);
      s.push_back(n16[7:0]);
      s.push_back(n16[15:8]);
      exp_err = (n > MAXW);
      nw = exp_err ? 0 : n;
      x = 8'h00;
      for (int k = 0; k < nw; k++) begin
         logic [31:0] w;
         w = (k < fixed_q.size()) ? fixed_q[k] : $urandom;
         for (int j = 0; j < 4; j++) begin
            s.push_back(w[8*j +: 8]);
            x ^= w[8*j +: 8];
         end
         exp_w.push_back({BASE + 32'(4 * k), w});
      end
`ifdef INST_LOADER_CHECKSUM_EN
      if (!exp_err) begin
         s.push_back(bad_csum ? ~x : x);
         exp_err = bad_csum;
      end
`endif
      exp_done = !exp_err;

      wr_q.delete();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < s.size(); i++) begin
         gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 3);
         send_byte(s[i], gap, ok);
         if (!ok) begin
            chk("byte_accept_timeout", 0, 1);
            break;
         end
         if (i >= 5 && ((i - 2) % 4) == 3 && i < 2 + 4 * nw)
            chk("wr_latency", is_write, 1);
      end
`ifndef INST_LOADER_CHECKSUM_EN
      if (nw > 0) begin
         @(posedge clk); #1;
         chk("done_latency", done, 1);
      end
`endif
      for (int c = 0; c < 20 && !(done || error); c++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("done", done, exp_done);
      chk("error", error, exp_err);
      chk("core_hold", core_hold, !exp_done);
      chk("byte_ready_end", byte_ready, 0);
      chk("words_loaded", words_loaded, exp_w.size());
      chk("n_writes", wr_q.size(), exp_w.size());
      for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++)
         chk("write_addr_data", wr_q[k], exp_w[k]);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("in_reset");
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_reset_values("idle");
      chk("idle_no_write", wr_q.size(), 0);

      // Two-word example, then the same stream with byte_valid toggling.
      fixed_q = {32'h0000_0013, 32'h00A0_00B3};
      session(2, 0, 1'b0);
      session(2, 1, 1'b0);
      fixed_q.delete();

      // Over-limit count, then an empty program.
      session(MAXW + 1, 0, 1'b0);
      session(0, 0, 1'b0);
      session(MAXW + 1, 2, 1'b0);

      // Single word with good and bad checksum (plain single-word loads without the feature).
      fixed_q = {32'h4433_2211};
      session(1, 0, 1'b0);
      session(1, 2, 1'b1);
      fixed_q.delete();

      // Reset after 5 payload bytes of a 3-word program.
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_byte(8'h03, 0, ok);
      send_byte(8'h00, 0, ok);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0, ok);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      session(3, 2, 1'b0);

      for (int r = 0; r < 25; r++) begin
         int n;
         n = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW + 1, 65535) : $urandom_range(0, 6);
         session(n, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
